// File: rtl/ak16_pkg.sv
// Shared types and constants for the ak16 boot path: loader states, length field width
// and the halt instruction used to terminate test images.
package ak16_pkg;

    typedef enum logic [2:0] {
        StHdrHi,
        StHdrLo,
        StDatHi,
        StDatLo,
        StChkHi,
        StChkLo,
        StDone,
        StErr
    } loader_state_e;

    localparam int unsigned LEN_W      = 16;
    localparam logic [15:0] HALT_INSTR = 16'h0F00;

endpackage

// File: rtl/imem_loader.sv
// Boot loader: length-prefixed big-endian byte stream -> imem words; holds the CPU in reset
// until loaded. IMEM_LOADER_CHECKSUM_EN adds a 16-bit sum trailer checked before release.
module imem_loader
    import ak16_pkg::*;
#(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DEPTH  = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [15:0]       imem_wdata,
    output logic              cpu_rst,
    output logic              load_done,
    output logic              load_err,
    output logic [ADDR_W:0]   word_count
);

    loader_state_e     state_q, state_d;
    logic [7:0]        len_hi_q, len_hi_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [7:0]        hi_q, hi_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [15:0]       wdata_q, wdata_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              cpu_rst_q, cpu_rst_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [15:0]       sum_q, sum_d;
`endif

    logic             accept;
    logic [LEN_W-1:0] len_new;
    logic [15:0]      word_new;
    logic             last_word;

    assign in_ready  = (state_q != StDone) && (state_q != StErr);
    assign accept    = in_valid && in_ready;
    assign len_new   = {len_hi_q, in_data};
    assign word_new  = {hi_q, in_data};
    assign last_word = (32'(count_q) + 32'd1) == 32'(len_q);

    always_comb begin
        state_d   = state_q;
        len_hi_d  = len_hi_q;
        len_d     = len_q;
        hi_d      = hi_q;
        we_d      = 1'b0;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        count_d   = count_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
        sum_d     = sum_q;
`endif
        // Status flags trail the terminal state by one cycle.
        done_d    = (state_q == StDone);
        err_d     = (state_q == StErr);
        cpu_rst_d = (state_q != StDone);

        if (accept) begin
            unique case (state_q)
                StHdrHi: begin
                    len_hi_d = in_data;
                    state_d  = StHdrLo;
                end
                StHdrLo: begin
                    len_d = len_new;
                    if (len_new == '0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                        state_d = StChkHi;
`else
                        state_d = StDone;
`endif
                    end else if (32'(len_new) > DEPTH) begin
                        state_d = StErr;
                    end else begin
                        state_d = StDatHi;
                    end
                end
                StDatHi: begin
                    hi_d    = in_data;
                    state_d = StDatLo;
                end
                StDatLo: begin
                    we_d    = 1'b1;
                    addr_d  = count_q[ADDR_W-1:0];
                    wdata_d = word_new;
                    count_d = count_q + {{ADDR_W{1'b0}}, 1'b1};
`ifdef IMEM_LOADER_CHECKSUM_EN
                    sum_d   = sum_q + word_new;
                    state_d = last_word ? StChkHi : StDatHi;
`else
                    state_d = last_word ? StDone : StDatHi;
`endif
                end
`ifdef IMEM_LOADER_CHECKSUM_EN
                StChkHi: begin
                    hi_d    = in_data;
                    state_d = StChkLo;
                end
                StChkLo: begin
                    state_d = (word_new == sum_q) ? StDone : StErr;
                end
`endif
                default: state_d = state_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StHdrHi;
            len_hi_q  <= '0;
            len_q     <= '0;
            hi_q      <= '0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            count_q   <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            cpu_rst_q <= 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            len_hi_q  <= len_hi_d;
            len_q     <= len_d;
            hi_q      <= hi_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            count_q   <= count_d;
            done_q    <= done_d;
            err_q     <= err_d;
            cpu_rst_q <= cpu_rst_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum_q     <= sum_d;
`endif
        end
    end

    assign imem_we    = we_q;
    assign imem_addr  = addr_q;
    assign imem_wdata = wdata_q;
    assign word_count = count_q;
    assign load_done  = done_q;
    assign load_err   = err_q;
    assign cpu_rst    = cpu_rst_q;

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
Boot-time program loader that sits upstream of cpu_top and drives the instruction-memory write port.
- Consumes a byte stream over a valid/ready handshake from a host or UART receiver.
- Assembles big-endian 16-bit instruction words and writes them to imem starting at address 0.
- Holds the CPU in reset (cpu_rst) until the whole image has been written. The CPU then fetches from PC=0.

Parameters:
ADDR_W, 8, imem address width.
DEPTH, 256, imem depth in words; maximum legal image length; must be <= 2**ADDR_W.

Ports:
clk  input  1  system clock; all logic on the rising edge.
rst  input  1  synchronous, active-high reset.
in_valid  input  1  byte on in_data is valid.
in_data  input  8  stream byte.
in_ready  output  1  loader accepts a byte this cycle.
imem_we  output  1  one-cycle imem write strobe.
imem_addr  output  ADDR_W  imem write address.
imem_wdata  output  16  imem write data.
cpu_rst  output  1  reset to cpu_top; high while loading or on error.
load_done  output  1  image loaded successfully (sticky).
load_err  output  1  image rejected (sticky).
word_count  output  ADDR_W+1  number of words written so far.

Behaviour:
- Reset values: imem_we=0, imem_addr=0, imem_wdata=0, cpu_rst=1, load_done=0, load_err=0, word_count=0, state=HDR_HI.
- Handshake:
  - A byte is accepted when in_valid && in_ready.
  - in_ready = 1 in HDR_HI, HDR_LO, DAT_HI, DAT_LO (and CHK_HI, CHK_LO); 0 in DONE and ERR.
  - in_ready is combinational from state only, never from in_valid.
  - Gaps in in_valid stall the current state indefinitely; there is no timeout.
- Stream format: LEN[15:8], LEN[7:0], then LEN words, each as high byte then low byte.
- States:
  - HDR_HI: accept byte -> len_hi; go to HDR_LO.
  - HDR_LO: accept byte; form LEN.
    - LEN==0 -> DONE.
    - LEN>DEPTH -> ERR.
    - Else -> DAT_HI.
  - DAT_HI: accept byte -> hi_reg; go to DAT_LO.
  - DAT_LO: accept byte. On the next cycle: imem_we=1, imem_addr=word_count[ADDR_W-1:0], imem_wdata={hi_reg,byte}. word_count increments in that same cycle.
    - If this was word LEN-1 -> DONE (or CHK_HI with the macro).
    - Else -> DAT_HI.
  - DONE: load_done=1, cpu_rst=0; both registered and first visible one cycle after the final imem_we pulse. Terminal until rst.
  - ERR: load_err=1, cpu_rst stays 1. Terminal until rst.
- imem_we is high for exactly one cycle per word; never two consecutive cycles, since a word takes at least 2 accepted bytes.
- imem_addr and imem_wdata hold their last values when imem_we=0.
- Back-to-back bytes: full throughput of 1 byte/cycle.
- Address wrap cannot occur because LEN<=DEPTH is enforced. LEN==DEPTH is legal and writes addresses 0..DEPTH-1.
- rst mid-load: all state and outputs return to reset values next edge; cpu_rst stays high. imem contents are not cleared; a partial image remains until overwritten.
- load_done and load_err are mutually exclusive and never both 1.

Optional Feature:
Macro IMEM_LOADER_CHECKSUM_EN.
- Defined:
  - Two trailer bytes CHK_HI, CHK_LO follow the data.
  - The loader keeps a 16-bit running sum (mod 2^16) of all data words.
  - Trailer matches the sum -> DONE; mismatch -> ERR.
  - LEN==0 still expects a trailer, which must be 0x0000.
- Undefined: no trailer; the CHK states and the sum register are absent; DAT_LO on the last word goes straight to DONE.

Decomposition:
- Shared package ak16_pkg:
  - loader state enum (HDR_HI, HDR_LO, DAT_HI, DAT_LO, CHK_HI, CHK_LO, DONE, ERR);
  - LEN field width 16;
  - HALT_INSTR constant 16'h0F00, used by benches for end-of-image programs.
- No sub-module required. The FSM, byte assembler and counter stay in one module.

Test Plan:
- Bytes 00 03 12 34 AB CD 0F 00 back-to-back -> writes (0,1234),(1,ABCD),(2,0F00). word_count=3. load_done=1 and cpu_rst=0 one cycle after the 3rd imem_we.
- Bytes 00 00 -> no imem_we. DONE; load_done=1, cpu_rst=0. in_ready=0 afterwards.
- Bytes 01 01 (LEN=257 > DEPTH) -> ERR. load_err=1, cpu_rst=1, no writes, in_ready=0.
- Same 3-word image with in_valid deasserted for 1–5 random cycles between bytes -> identical writes and order; no extra imem_we.
- rst pulsed after 5 bytes of a 3-word image, then the full image resent -> outputs at reset values after the rst edge; final imem holds the correct image; load_done=1.
- With IMEM_LOADER_CHECKSUM_EN, image 00 02 00 01 00 02:
  - trailer 00 03 -> DONE;
  - trailer 00 04 -> ERR with load_err=1 and cpu_rst=1.
